// File: rtl/serial_sub.sv
// serial_sub -- bit-serial W-bit subtractor computing a - b - bin.
//
// One full-subtractor cell is reused across W clock cycles, LSB first,
// with the borrow carried between bits in a single register. The
// controlling FSM uses a start/busy/done handshake to drive it.
//
// Parameters:
//   W      operand/result width in bits (2..32)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request; sampled only while busy=0 (IDLE or DONE)
//   a      in   [W] minuend, captured on the accepting edge
//   b      in   [W] subtrahend, captured on the accepting edge
//   bin    in   borrow-in, captured on the accepting edge
//   d      out  [W] difference, valid from done until the next accept
//   bout   out  borrow-out (1 when a < b + bin, unsigned)
//   busy   out  high while a subtraction is in progress
//   done   out  one-cycle pulse marking the result valid
//   ovf    out  signed overflow, present only when SERIAL_SUB_OVF_EN
//                is defined
//
// Optional feature macro: SERIAL_SUB_OVF_EN

module serial_sub #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic         ovf,
`endif
  output logic         busy,
  output logic         done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  d_q;
  logic [CW-1:0] cnt_q;
  logic          br_q;
  logic          bout_q;
  logic          busy_q;
  logic          done_q;
`ifdef SERIAL_SUB_OVF_EN
  logic          ovf_q;
`endif

  // Full-subtractor cell acting on the bit selected by the counter.
  logic ai_d;
  logic bi_d;
  logic diff_d;
  logic br_d;

  always_comb begin
    ai_d   = a_q[cnt_q];
    bi_d   = b_q[cnt_q];
    diff_d = ai_d ^ bi_d ^ br_q;
    br_d   = (~ai_d & bi_d) | (~(ai_d ^ bi_d) & br_q);
  end

  // Control FSM and datapath registers. DONE accepts a new start just
  // like IDLE so back-to-back operations run at one result per W+1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          d_q[cnt_q] <= diff_d;
          br_q       <= br_d;
          if (cnt_q == LAST) begin
            // Final bit: publish the borrow and hand the result over.
            cnt_q   <= '0;
            bout_q  <= br_d;
`ifdef SERIAL_SUB_OVF_EN
            // Borrow into the MSB cell differs from borrow out of it.
            ovf_q   <= br_q ^ br_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign d    = d_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub -- self-checking bench for serial_sub at W=4.
//
// Applies a table of directed subtraction vectors with hand-computed
// results, then hand-written sequences for back-to-back handshake,
// reset mid-operation and simultaneous reset/start.
// Optional feature macro: SERIAL_SUB_OVF_EN (checks ovf when defined).

module tb_serial_sub;

  localparam int W = 4;
  localparam int TIMEOUT = 20;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] d;
  logic         bout;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int compared;
  int mismatched;

  serial_sub #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .d     (d),
    .bout  (bout),
`ifdef SERIAL_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] expD;
    logic         expBout;
    logic         expOvf;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after an accepting edge; reports edges elapsed and
  // how many of the sampled cycles had busy high.
  task automatic waitDone(output int lat, output int busyCycles);
    lat = 0;
    busyCycles = 0;
    while (!done && lat < TIMEOUT) begin
      if (busy) busyCycles++;
      tick();
      lat++;
    end
    if (lat >= TIMEOUT) checkOutput("done_timeout", 32'(lat), 32'(W));
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    int busyCycles;
    a = v.a;
    b = v.b;
    bin = v.bin;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(lat, busyCycles);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(W));
    checkOutput({tag, "_busyCycles"}, 32'(busyCycles), 32'(W));
    checkOutput({tag, "_busyAtDone"}, 32'(busy), 32'(0));
    checkOutput({tag, "_d"}, 32'(d), 32'(v.expD));
    checkOutput({tag, "_bout"}, 32'(bout), 32'(v.expBout));
`ifdef SERIAL_SUB_OVF_EN
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(v.expOvf));
`endif
    tick();
    checkOutput({tag, "_donePulse"}, 32'(done), 32'(0));
    checkOutput({tag, "_dHold"}, 32'(d), 32'(v.expD));
  endtask

  initial begin
    int lat;
    int busyCycles;
    int sawDone;
    vec_t v;

    compared = 0;
    mismatched = 0;

    //          a     b     bin  d     bout  ovf
    vecs[0] = '{4'h7, 4'h3, 1'b0, 4'h4, 1'b0, 1'b0};
    vecs[1] = '{4'h3, 4'h7, 1'b0, 4'hC, 1'b1, 1'b0};
    vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[3] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[4] = '{4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1};
    vecs[5] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1};
    vecs[6] = '{4'h5, 4'h2, 1'b0, 4'h3, 1'b0, 1'b0};
    vecs[7] = '{4'h5, 4'h5, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[8] = '{4'hA, 4'h3, 1'b1, 4'h6, 1'b0, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    tick();
    tick();
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_done", 32'(done), 32'(0));
    checkOutput("reset_d", 32'(d), 32'(0));
    checkOutput("reset_bout", 32'(bout), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("reset_ovf", 32'(ovf), 32'(0));
`endif
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: start held high; inputs change during the first RUN
    // and must not disturb the first result.
    a = 4'h5;
    b = 4'h2;
    bin = 1'b0;
    start = 1'b1;
    tick();
    a = 4'h9;
    b = 4'h9;
    waitDone(lat, busyCycles);
    checkOutput("b2b_first_latency", 32'(lat), 32'(W));
    checkOutput("b2b_first_d", 32'(d), 32'(4'h3));
    checkOutput("b2b_first_bout", 32'(bout), 32'(0));
    tick();
    start = 1'b0;
    checkOutput("b2b_second_busy", 32'(busy), 32'(1));
    waitDone(lat, busyCycles);
    checkOutput("b2b_second_latency", 32'(lat + 1), 32'(W + 1));
    checkOutput("b2b_second_d", 32'(d), 32'(4'h0));
    checkOutput("b2b_second_bout", 32'(bout), 32'(0));
    tick();

    // Start pulses and operand changes during RUN are ignored.
    a = 4'hC;
    b = 4'h4;
    bin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    a = 4'h1;
    b = 4'hE;
    bin = 1'b1;
    tick();
    start = 1'b0;
    waitDone(lat, busyCycles);
    checkOutput("runIgnore_latency", 32'(lat + 2), 32'(W));
    checkOutput("runIgnore_d", 32'(d), 32'(4'h8));
    checkOutput("runIgnore_bout", 32'(bout), 32'(0));
    tick();
    checkOutput("runIgnore_idle", 32'(busy), 32'(0));

    // Reset in the second RUN cycle discards the operation.
    a = 4'h8;
    b = 4'h1;
    bin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midReset_busy", 32'(busy), 32'(0));
    checkOutput("midReset_done", 32'(done), 32'(0));
    checkOutput("midReset_d", 32'(d), 32'(0));
    checkOutput("midReset_bout", 32'(bout), 32'(0));
    sawDone = 0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      if (done || busy) sawDone = 1;
    end
    checkOutput("midReset_noDone", 32'(sawDone), 32'(0));
    v = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1};
    applyStimulus(v, "afterReset");

    // Reset and start together: reset wins.
    a = 4'h6;
    b = 4'h1;
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    checkOutput("rstStart_busy", 32'(busy), 32'(0));
    tick();
    checkOutput("rstStart_stayIdle", 32'(busy), 32'(0));
    checkOutput("rstStart_d", 32'(d), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
